// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter: serialises a UART frame LSB first, one bit per baud tick, with busy/done handshake
module uart_tx_shifter #(
    parameter int FRAME_W = 11,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               baud_tick,
    input  logic               send,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic [1:0]         parity_type,
    input  logic               data_length,
    input  logic               stop_bits,
    output logic               tx_out,
    output logic               busy,
    output logic               done
);
    localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, SHIFT = 2'd2;

    logic [1:0]         state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt, nbits, n_raw, n_cfg;

    // frame length from the live config: start + 7/8 data + optional parity + 1/2 stop, clamped to the register width
    always_comb begin
        n_raw = CNT_W'(9) + CNT_W'(data_length) + CNT_W'(parity_type[0] ^ parity_type[1]) + CNT_W'(stop_bits);
        n_cfg = (n_raw > CNT_W'(FRAME_W)) ? CNT_W'(FRAME_W) : n_raw;
    end

    // IDLE latches the frame, ARM aligns the start bit to a full baud period, SHIFT walks the bits out
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            shreg  <= '1;
            cnt    <= '0;
            nbits  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (send) begin
                        shreg <= frame_in;
                        nbits <= n_cfg;
                        busy  <= 1'b1;
                        state <= ARM;
                    end
                end
                ARM: if (baud_tick) begin
                    tx_out <= shreg[0];
                    shreg  <= {1'b1, shreg[FRAME_W-1:1]};
                    cnt    <= '0;
                    state  <= SHIFT;
                end
                SHIFT: if (baud_tick) begin
                    if (cnt == nbits - 1'b1) begin
                        tx_out <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        tx_out <= shreg[0];
                        shreg  <= {1'b1, shreg[FRAME_W-1:1]};
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_shifter.sv
// tb_uart_tx_shifter: directed and randomised frames checked against a bit-list model of the line
module tb_uart_tx_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        baud_tick = 1'b0;
    logic        send = 1'b0;
    logic [10:0] frame_in = '0;
    logic [1:0]  parity_type = '0;
    logic        data_length = 1'b0;
    logic        stop_bits = 1'b0;
    logic        tx_out, busy, done;
    int          cy = 0;
    int          npass = 0;
    int          ntot = 0;

    uart_tx_shifter dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .send(send), .frame_in(frame_in),
        .parity_type(parity_type), .data_length(data_length), .stop_bits(stop_bits),
        .tx_out(tx_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // advance one clock; baud ticks land on every edge whose index is a multiple of 16
    task automatic cyc();
        @(posedge clk);
        #1;
        cy++;
        baud_tick = ((cy + 1) % 16 == 0);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // mode: 0 plain, 1 resend+config change mid-frame, 2 reset during data bit 3, 3 back-to-back gap check
    task automatic run_frame(input logic [10:0] fr, input logic [1:0] pt, input logic dl, input logic sb, input int mode);
        int nb, n, a, exp_n;
        logic ds, bl;
        nb = 1 + (dl ? 8 : 7) + ((pt == 2'b01 || pt == 2'b10) ? 1 : 0) + (sb ? 2 : 1);
        if (nb > 11) nb = 11;
        frame_in = fr; parity_type = pt; data_length = dl; stop_bits = sb; send = 1'b1;
        cyc();
        send = 1'b0;
        a = cy;
        chk("busy_on_accept", busy, 1);
        chk("done_one_clk", done, 0);
        exp_n = (a / 16 + 1) * 16 - a;
        n = 0;
        while (tx_out !== 1'b0 && n < 40) begin
            cyc();
            n++;
        end
        chk("start_latency", n, exp_n);
        if (mode == 3) chk("b2b_gap", n, 15);
        ds = 1'b0;
        bl = 1'b0;
        for (int k = 0; k < nb * 16; k++) begin
            if (k % 16 == 0 || k % 16 == 15) chk($sformatf("bit%0d", k / 16), tx_out, fr[k / 16]);
            ds |= done;
            bl |= !busy;
            if (mode == 1 && k == 40) begin
                send = 1'b1; frame_in = ~fr; data_length = !dl; stop_bits = !sb;
            end
            if (mode == 1 && k == 42) send = 1'b0;
            if (mode == 2 && k == 4 * 16 + 8) begin
                rst = 1'b0;
                cyc();
                rst = 1'b1;
                chk("rst_tx", tx_out, 1);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                for (int j = 0; j < 200; j++) begin
                    ds |= done | !tx_out | busy;
                    cyc();
                end
                chk("rst_quiet", ds, 0);
                return;
            end
            cyc();
        end
        chk("no_early_done", ds, 0);
        chk("busy_held", bl, 0);
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("stop_idle", tx_out, 1);
    endtask

    initial begin
        logic [10:0] fr;
        logic [1:0]  pt;
        logic        dl, sb;
        cyc();
        cyc();
        chk("reset_tx", tx_out, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b1;
        repeat (5) cyc();
        run_frame(11'h2AA, 2'b00, 1'b1, 1'b0, 0);
        repeat (7) cyc();
        run_frame({2'b11, 1'b0, 7'h41, 1'b0}, 2'b01, 1'b0, 1'b1, 0);
        run_frame({2'b00, 1'b1, 7'h7F, 1'b0}, 2'b11, 1'b0, 1'b0, 3);
        repeat (3) cyc();
        run_frame(11'h5B4, 2'b10, 1'b1, 1'b1, 1);
        cyc();
        chk("no_second_frame_busy", busy, 0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("no_second_frame_tx", tx_out, 1);
        end
        while (cy % 16 != 15) cyc();
        run_frame(11'h3C6, 2'b00, 1'b1, 1'b0, 0);
        repeat (4) cyc();
        run_frame(11'h2AA, 2'b00, 1'b1, 1'b0, 2);
        run_frame(11'h1F2, 2'b01, 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            fr = 11'($urandom);
            fr[0] = 1'b0;
            pt = 2'($urandom);
            dl = 1'($urandom);
            sb = 1'($urandom);
            if (i % 3 != 2) repeat ($urandom_range(0, 20)) cyc();
            run_frame(fr, pt, dl, sb, (i % 3 == 2) ? 3 : 0);
        end
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
